word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer.sv | 122 ++++++++++++
 tb/tb_word_serializer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// Word-to-bit serializer with optional differential (DPSK) encoding.
// Accepts a word when idle or at the last clock of a word, then emits one bit every CLKS_PER_BIT cycles.
//
// state | meaning
// IDLE  | no word in flight, word_ready high, outputs low
// SHIFT | emitting bits of the captured word
module word_serializer #(
    parameter int WORD_W       = 12,
    parameter int CLKS_PER_BIT = 1,
    parameter int MSB_FIRST    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] word,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic              dpsk_en,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              last
);

    localparam int IDX_W  = $clog2(WORD_W);
    localparam int HOLD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0]  IDX_PENULT = IDX_W'(WORD_W - 2);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(CLKS_PER_BIT - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state, state_nxt;
    logic [WORD_W-1:0]   shift_reg, shift_nxt;
    logic                mode_reg, mode_nxt;
    logic [IDX_W-1:0]    bit_idx, idx_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic                ref_bit, ref_nxt;
    logic                bit_out_nxt, bit_valid_nxt, last_nxt;
    logic                accept;
    logic                at_boundary;

    assign at_boundary = (state == SHIFT) && (bit_idx == IDX_LAST) && (hold_cnt == HOLD_LAST);
    assign word_ready  = !rst && ((state == IDLE) || at_boundary);
    assign accept      = word_valid && word_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            mode_reg  <= 1'b0;
            bit_idx   <= '0;
            hold_cnt  <= '0;
            ref_bit   <= 1'b0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            last      <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            mode_reg  <= mode_nxt;
            bit_idx   <= idx_nxt;
            hold_cnt  <= hold_nxt;
            ref_bit   <= ref_nxt;
            bit_out   <= bit_out_nxt;
            bit_valid <= bit_valid_nxt;
            last      <= last_nxt;
        end
    end

    // shift_reg holds the bits not yet sent, aligned so the next one sits at the output end
    always_comb begin
        state_nxt     = state;
        shift_nxt     = shift_reg;
        mode_nxt      = mode_reg;
        idx_nxt       = bit_idx;
        hold_nxt      = hold_cnt;
        ref_nxt       = ref_bit;
        bit_out_nxt   = bit_out;
        bit_valid_nxt = bit_valid;
        last_nxt      = last;
        if (accept) begin
            state_nxt     = SHIFT;
            mode_nxt      = dpsk_en;
            idx_nxt       = '0;
            hold_nxt      = '0;
            bit_valid_nxt = 1'b1;
            last_nxt      = 1'b0;
            if (MSB_FIRST != 0) begin
                shift_nxt   = {word[WORD_W-2:0], 1'b0};
                bit_out_nxt = word[WORD_W-1] ^ (dpsk_en & ref_bit);
            end else begin
                shift_nxt   = {1'b0, word[WORD_W-1:1]};
                bit_out_nxt = word[0] ^ (dpsk_en & ref_bit);
            end
            ref_nxt = bit_out_nxt;
        end else if (state == SHIFT) begin
            if (hold_cnt != HOLD_LAST) begin
                hold_nxt = hold_cnt + HOLD_W'(1);
            end else if (bit_idx != IDX_LAST) begin
                hold_nxt = '0;
                idx_nxt  = bit_idx + IDX_W'(1);
                last_nxt = (bit_idx == IDX_PENULT);
                if (MSB_FIRST != 0) begin
                    shift_nxt   = {shift_reg[WORD_W-2:0], 1'b0};
                    bit_out_nxt = shift_reg[WORD_W-1] ^ (mode_reg & ref_bit);
                end else begin
                    shift_nxt   = {1'b0, shift_reg[WORD_W-1:1]};
                    bit_out_nxt = shift_reg[0] ^ (mode_reg & ref_bit);
                end
                ref_nxt = bit_out_nxt;
            end else begin
                // ref_bit deliberately kept: DPSK reference spans idle gaps
                state_nxt     = IDLE;
                hold_nxt      = '0;
                idx_nxt       = '0;
                bit_out_nxt   = 1'b0;
                bit_valid_nxt = 1'b0;
                last_nxt      = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: default instance plus a CLKS_PER_BIT=3, LSB-first instance.
module tb_word_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] word;
    logic        word_valid, dpsk_en;
    logic        word_ready, bit_out, bit_valid, last;
    logic [11:0] word1;
    logic        word_valid1, dpsk_en1;
    logic        word_ready1, bit_out1, bit_valid1, last1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    word_serializer u_dut (
        .clk(clk), .rst(rst), .word(word), .word_valid(word_valid), .word_ready(word_ready),
        .dpsk_en(dpsk_en), .bit_out(bit_out), .bit_valid(bit_valid), .last(last)
    );

    word_serializer #(.WORD_W(12), .CLKS_PER_BIT(3), .MSB_FIRST(0)) u_slow (
        .clk(clk), .rst(rst), .word(word1), .word_valid(word_valid1), .word_ready(word_ready1),
        .dpsk_en(dpsk_en1), .bit_out(bit_out1), .bit_valid(bit_valid1), .last(last1)
    );

    typedef struct {
        logic [11:0] w;
        logic        d;
        logic [11:0] exp_bits;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one word for a single accepting cycle and record the 12 following cycles.
    task automatic run_word(input logic [11:0] w, input logic d, input bit disturb,
                            output logic [11:0] bits, output logic [11:0] lasts,
                            output logic [11:0] readys, output int nval);
        bits = '0; lasts = '0; readys = '0; nval = 0;
        @(negedge clk);
        check("ready_before_accept", 64'(word_ready), 64'd1);
        word = w; dpsk_en = d; word_valid = 1'b1;
        @(posedge clk);
        #1;
        word_valid = 1'b0; word = 12'h3C3; dpsk_en = ~d;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bits   = {bits[10:0], bit_out};
            lasts  = {lasts[10:0], last};
            readys = {readys[10:0], word_ready};
            nval  += int'(bit_valid);
            if (disturb) begin
                if (i < 11) begin
                    word_valid = 1'($urandom_range(0, 1));
                    word       = 12'($urandom);
                    dpsk_en    = 1'($urandom_range(0, 1));
                end else begin
                    word_valid = 1'b0;
                end
            end
        end
        @(negedge clk);
        check("idle_after_word", {61'd0, bit_valid, bit_out, last}, 64'd0);
    endtask

    logic [11:0] bits, lasts, readys;
    logic [23:0] bits24, rdy24;
    logic [35:0] bits36, last36, rdy36;
    int          nval;

    initial begin
        vecs[0] = '{12'hA5C, 1'b0, 12'hA5C};
        vecs[1] = '{12'hFFF, 1'b1, 12'hAAA};
        vecs[2] = '{12'h000, 1'b1, 12'h000};
        vecs[3] = '{12'h001, 1'b0, 12'h001};
        vecs[4] = '{12'h000, 1'b1, 12'hFFF};
        vecs[5] = '{12'h800, 1'b1, 12'h000};
        vecs[6] = '{12'h5A3, 1'b1, 12'h6C2};

        rst = 1'b1; word = '0; word_valid = 1'b1; dpsk_en = 1'b0;
        word1 = '0; word_valid1 = 1'b0; dpsk_en1 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {60'd0, bit_out, bit_valid, last, word_ready}, 64'd0);
        check("reset_outputs_slow", {60'd0, bit_out1, bit_valid1, last1, word_ready1}, 64'd0);
        word_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(word_ready), 64'd1);
        check("no_accept_in_reset", 64'(bit_valid), 64'd0);

        foreach (vecs[k]) begin
            run_word(vecs[k].w, vecs[k].d, 1'b0, bits, lasts, readys, nval);
            check($sformatf("bits_vec%0d", k), 64'(bits), 64'(vecs[k].exp_bits));
            check($sformatf("last_vec%0d", k), 64'(lasts), 64'h001);
            check($sformatf("ready_vec%0d", k), 64'(readys), 64'h001);
            check($sformatf("nvalid_vec%0d", k), 64'(nval), 64'd12);
        end

        // Back-to-back: 800 then 001 raw with word_valid held high; ref is 0 here.
        @(negedge clk);
        word = 12'h800; dpsk_en = 1'b0; word_valid = 1'b1;
        @(posedge clk);
        #1 word = 12'h001;
        bits24 = '0; rdy24 = '0; nval = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            bits24 = {bits24[22:0], bit_out};
            rdy24  = {rdy24[22:0], word_ready};
            nval  += int'(bit_valid);
            if (i == 11) begin
                @(posedge clk);
                #1 word_valid = 1'b0;
            end
        end
        check("b2b_bits", 64'(bits24), 64'h800001);
        check("b2b_ready", 64'(rdy24), 64'h001001);
        check("b2b_nvalid", 64'(nval), 64'd24);
        @(negedge clk);
        check("b2b_idle", 64'(bit_valid), 64'd0);

        // ref is 1 after the 001 word: 5A3 DPSK -> ~6C2 pattern, with bus noise during the word.
        run_word(12'h5A3, 1'b1, 1'b1, bits, lasts, readys, nval);
        check("disturb_bits", 64'(bits), 64'h93D);
        check("disturb_nvalid", 64'(nval), 64'd12);
        word_valid = 1'b0;

        // Reset during bit 5 of an all-ones raw word leaves ref at 1 unless cleared.
        @(negedge clk);
        word = 12'hFFF; dpsk_en = 1'b0; word_valid = 1'b1;
        @(posedge clk);
        #1 word_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_valid", 64'(bit_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midword_reset", {61'd0, bit_valid, bit_out, last}, 64'd0);
        check("ready_in_reset", 64'(word_ready), 64'd0);
        rst = 1'b0;
        run_word(12'hFFF, 1'b1, 1'b0, bits, lasts, readys, nval);
        check("post_reset_dpsk", 64'(bits), 64'hAAA);

        // Slow instance: 001 raw, LSB first, 3 clocks per bit.
        @(negedge clk);
        check("slow_ready", 64'(word_ready1), 64'd1);
        word1 = 12'h001; dpsk_en1 = 1'b0; word_valid1 = 1'b1;
        @(posedge clk);
        #1 word_valid1 = 1'b0; word1 = 12'hFFF;
        bits36 = '0; last36 = '0; rdy36 = '0; nval = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            bits36 = {bits36[34:0], bit_out1};
            last36 = {last36[34:0], last1};
            rdy36  = {rdy36[34:0], word_ready1};
            nval  += int'(bit_valid1);
        end
        check("slow_bits", 64'(bits36), 64'hE00000000);
        check("slow_last", 64'(last36), 64'h7);
        check("slow_ready_pulse", 64'(rdy36), 64'h1);
        check("slow_nvalid", 64'(nval), 64'd36);
        @(negedge clk);
        check("slow_idle", 64'(bit_valid1), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
